// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer: level width, debounce default and decode direction.
package rgb_mixer_pkg;

  localparam int unsigned LEVEL_WIDTH             = 8;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_e;

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw mechanical input.
module debounce
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // The count restarts whenever the synced input agrees with the accepted value again.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rotary_level.sv
// Quadrature rotary encoder to N-bit brightness level: debounce, x1 decode, saturating/wrapping step.
module rotary_level
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned     WIDTH           = LEVEL_WIDTH,
  parameter int unsigned     DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned     STEP            = 1,
  parameter bit              SATURATE        = 1'b1,
  parameter logic [WIDTH-1:0] RESET_LEVEL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] level,
  output logic             step_up,
  output logic             step_down
);

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

  logic           deb_a;
  logic           deb_b;
  logic           prev_a;
  logic           prev_b;
  dir_e           dir_c;
  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] diff_c;
  logic [WIDTH-1:0] level_up_c;
  logic [WIDTH-1:0] level_dn_c;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk    (clk),
    .reset  (reset),
    .raw    (enc_a),
    .stable (deb_a)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk    (clk),
    .reset  (reset),
    .raw    (enc_b),
    .stable (deb_b)
  );

  // x1 decode on a rising A with B steady; B level selects the direction.
  always_comb begin
    dir_c = DIR_NONE;
    if (!prev_a && deb_a && (deb_b == prev_b)) begin
      dir_c = deb_b ? DIR_DOWN : DIR_UP;
    end
  end

  // Arithmetic in WIDTH+1 bits so the top bit flags overflow or underflow.
  always_comb begin
    sum_c      = {1'b0, level} + STEP_EXT;
    diff_c     = {1'b0, level} - STEP_EXT;
    level_up_c = (SATURATE && sum_c[WIDTH])  ? '1 : sum_c[WIDTH-1:0];
    level_dn_c = (SATURATE && diff_c[WIDTH]) ? '0 : diff_c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_a    <= 1'b0;
      prev_b    <= 1'b0;
      level     <= RESET_LEVEL;
      step_up   <= 1'b0;
      step_down <= 1'b0;
    end else begin
      prev_a    <= deb_a;
      prev_b    <= deb_b;
      step_up   <= (dir_c == DIR_UP);
      step_down <= (dir_c == DIR_DOWN);
      case (dir_c)
        DIR_UP:   level <= level_up_c;
        DIR_DOWN: level <= level_dn_c;
        default:  level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_level.sv
// Bench for rotary_level: directed detent scenarios plus random encoder activity against a window-based model.
module tb_rotary_level;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] level_s, level_w;
  logic       up_s, dn_s, up_w, dn_w;

  int n_checks = 0;
  int n_errors = 0;
  int n_up, n_dn;
  bit chk_en = 0;

  // Saturating, step 1, reset 0x80.
  rotary_level #(.WIDTH(8), .DEBOUNCE_CYCLES(DEB), .STEP(1), .SATURATE(1'b1), .RESET_LEVEL(8'h80)) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .level(level_s), .step_up(up_s), .step_down(dn_s));

  // Wrapping, step 16, reset 0xF8.
  rotary_level #(.WIDTH(8), .DEBOUNCE_CYCLES(DEB), .STEP(16), .SATURATE(1'b0), .RESET_LEVEL(8'hF8)) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .level(level_w), .step_up(up_w), .step_down(dn_w));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw samples delayed two edges, accepted after DEB consecutive differing samples.
  bit r1a, r2a, r1b, r2b, sa, sb;
  bit deb_a, deb_b, prv_a, prv_b, ev_up, ev_dn;
  bit win_a[$];
  bit win_b[$];
  bit m_up, m_dn;
  int unsigned lvl_s, lvl_w;

  function automatic bit all_differ(input bit q[$], input bit d);
    if (q.size() != DEB) return 1'b0;
    foreach (q[i]) if (q[i] == d) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int unsigned next_lvl(input int unsigned l, input bit up,
                                           input int unsigned step, input bit sat);
    int v;
    v = up ? int'(l) + int'(step) : int'(l) - int'(step);
    if (sat) begin
      if (v > 255) v = 255;
      if (v < 0) v = 0;
    end else begin
      v = (v + 256) % 256;
    end
    return int'(v);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      r1a = 0; r2a = 0; r1b = 0; r2b = 0;
      deb_a = 0; deb_b = 0; prv_a = 0; prv_b = 0;
      win_a.delete(); win_b.delete();
      m_up = 0; m_dn = 0;
      lvl_s = 32'h80; lvl_w = 32'hF8;
    end else begin
      sa = r2a; sb = r2b;
      r2a = r1a; r1a = enc_a;
      r2b = r1b; r1b = enc_b;
      ev_up = !prv_a && deb_a && (deb_b == prv_b) && !deb_b;
      ev_dn = !prv_a && deb_a && (deb_b == prv_b) && deb_b;
      prv_a = deb_a; prv_b = deb_b;
      win_a.push_back(sa); if (win_a.size() > DEB) void'(win_a.pop_front());
      win_b.push_back(sb); if (win_b.size() > DEB) void'(win_b.pop_front());
      if (all_differ(win_a, deb_a)) deb_a = sa;
      if (all_differ(win_b, deb_b)) deb_b = sb;
      m_up = ev_up; m_dn = ev_dn;
      if (ev_up) begin lvl_s = next_lvl(lvl_s, 1, 1, 1); lvl_w = next_lvl(lvl_w, 1, 16, 0); end
      if (ev_dn) begin lvl_s = next_lvl(lvl_s, 0, 1, 1); lvl_w = next_lvl(lvl_w, 0, 16, 0); end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("level_s", 32'(level_s), lvl_s);
      check("level_w", 32'(level_w), lvl_w);
      check("up_s", 32'(up_s), 32'(m_up));
      check("dn_s", 32'(dn_s), 32'(m_dn));
      check("up_w", 32'(up_w), 32'(m_up));
      check("dn_w", 32'(dn_w), 32'(m_dn));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (up_s) n_up++;
    if (dn_s) n_dn++;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic detent(input bit down);
    enc_b = down; hold(6);
    enc_a = 1'b1; hold(6);
    enc_a = 1'b0; hold(6);
  endtask

  task automatic do_reset();
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0;
    hold(2);
    reset = 1'b0;
    hold(2);
  endtask

  initial begin
    int k;
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0;
    n_up = 0; n_dn = 0;
    hold(2);
    chk_en = 1;
    hold(1);
    check("rst_level_s", 32'(level_s), 32'h80);
    check("rst_level_w", 32'(level_w), 32'hF8);
    check("rst_pulses", 32'({up_s, dn_s, up_w, dn_w}), 0);
    reset = 1'b0;
    hold(3);

    // Latency of a clockwise detent and wrap on the step-16 instance.
    enc_a = 1'b1;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick();
      if (up_s) k = i;
    end
    check("lat_up", 32'(k - 1), DEB + 2);
    check("cw_level_s", 32'(level_s), 32'h81);
    check("cw_level_w", 32'(level_w), 32'h08);
    tick();
    check("up_one_cycle", 32'(up_s), 0);
    hold(6);
    enc_a = 1'b0; hold(6);
    n_dn = 0;
    detent(1'b1);
    check("ccw_pulses", 32'(n_dn), 1);
    check("ccw_level_s", 32'(level_s), 32'h80);
    check("ccw_level_w", 32'(level_w), 32'hF8);

    // Bounce rejection: short high glitches then a firm hold.
    enc_b = 1'b0; hold(8);
    n_up = 0;
    for (int i = 0; i < 3; i++) begin
      enc_a = 1'b1; hold(int'($urandom_range(1, 3)));
      enc_a = 1'b0; hold(int'($urandom_range(1, 2)));
    end
    enc_a = 1'b1; hold(12);
    enc_a = 1'b0; hold(12);
    check("bounce_pulses", 32'(n_up), 1);
    check("bounce_level", 32'(level_s), 32'h81);

    // Reset while A's debounce count is pending.
    enc_a = 1'b1; hold(3);
    reset = 1'b1; enc_a = 1'b0;
    tick();
    check("midrst_level", 32'(level_s), 32'h80);
    reset = 1'b0;
    n_up = 0; n_dn = 0;
    hold(20);
    check("midrst_no_pulse", 32'(n_up + n_dn), 0);

    // Saturation at both ends.
    for (int i = 0; i < 127; i++) detent(1'b0);
    check("sat_reach_ff", 32'(level_s), 32'hFF);
    n_up = 0;
    for (int i = 0; i < 3; i++) detent(1'b0);
    check("sat_hi_pulses", 32'(n_up), 3);
    check("sat_hi_level", 32'(level_s), 32'hFF);
    for (int i = 0; i < 255; i++) detent(1'b1);
    check("sat_reach_00", 32'(level_s), 32'h00);
    n_dn = 0;
    detent(1'b1);
    check("sat_lo_pulses", 32'(n_dn), 1);
    check("sat_lo_level", 32'(level_s), 32'h00);

    // A and B rising together is not a detent; a following valid one is.
    do_reset();
    hold(6);
    n_up = 0; n_dn = 0;
    enc_a = 1'b1; enc_b = 1'b1; hold(10);
    check("inv_pulses", 32'(n_up + n_dn), 0);
    check("inv_level", 32'(level_s), 32'h80);
    enc_a = 1'b0; hold(8);
    enc_a = 1'b1; hold(8);
    enc_a = 1'b0; hold(8);
    check("after_inv_dn", 32'(n_dn), 1);
    check("after_inv_level", 32'(level_s), 32'h7F);

    // Random encoder activity, including bounces and simultaneous changes.
    for (int i = 0; i < 500; i++) begin
      enc_a = 1'($urandom);
      if ($urandom_range(0, 3) != 0) enc_b = 1'($urandom);
      hold(int'($urandom_range(1, 12)));
      if (up_s && dn_s) check("both_pulses", 1, 0);
    end
    hold(20);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
